debug_trace_unit: RTL and testbench
===================================

# debug_trace_unit

Parametrised trace-capture successor to the combinational debug read-out mux. It samples NCH probe channels of DW bits into a DEPTH-entry circular buffer whenever probe_valid is high. Capture stops a programmable number of samples after a masked-compare trigger, and halt can optionally be raised on completion. Captured data and status are read back over the existing chk_addr/chk_data debug bus with a registered, 1-cycle read. It sits beside the CPU debug mux, and its chk_data is ORed into the debug bus.

## Interface
- DW, 32: probe channel width, 1..32; read data is zero-extended to 32 bits.
- NCH, 8: probe channel count, 1..16.
- DEPTH, 64: trace entries, a power of 2, at least 2; AW = log2(DEPTH).
- clk  in  1  system clock, all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- probe_bus  in  NCH*DW  probe words; channel k is at [k*DW +: DW].
- probe_valid  in  1  sample strobe, typically WB commit.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  3  config register select.
- cfg_wdata  in  32  config write data.
- chk_addr  in  32  debug address.
- chk_data  out  32  registered debug read data.
- trace_state  out  2  0 = IDLE, 1 = ARMED, 2 = POST, 3 = DONE.
- halt  out  1  equals (trace_state == DONE) && halt_en.

## Operation
- Config registers are written when cfg_we = 1. All reset to 0.
  - Address 0, ctrl: bit0 = arm (command, not stored), bit1 = halt_en (stored), bit2 = clear (command, not stored).
  - Address 1: trig_ch [3:0].
  - Address 2: trig_value [DW-1:0].
  - Address 3: trig_mask [DW-1:0].
  - Address 4: post_count [AW-1:0]. Writes above DEPTH-1 saturate to DEPTH-1.
  - Other addresses are ignored.
- Commands:
  - clear: state goes to IDLE, and wr_ptr, sample_cnt and trig_ptr are zeroed.
  - arm: the same counters are zeroed, and state goes to ARMED.
  - clear and arm in the same write: clear wins.
  - A probe_valid in the same cycle as either command is not captured.
- Capture: in ARMED or POST, when probe_valid = 1:
  - All channels are written to mem[wr_ptr], and wr_ptr increments modulo DEPTH.
  - sample_cnt increments, saturating at DEPTH.
- Trigger: in ARMED, a captured sample with ((probe[trig_ch] ^ trig_value) & trig_mask) == 0 fires the trigger.
  - trig_ptr is set to that sample's wr_ptr.
  - If post_count == 0, state goes to DONE. Otherwise state goes to POST with remain = post_count.
  - trig_ch >= NCH never fires.
  - trig_mask = 0 fires on the first valid sample.
- POST: each captured sample decrements remain. The sample that takes remain from 1 to 0 is stored, and state goes to DONE.
- DONE and IDLE: no capture. Configuration can be rewritten; changes take effect on the next compare.
- Reads: oldest = (wr_ptr - sample_cnt) mod DEPTH; logical entry e maps to mem[(oldest + e) mod DEPTH].
  - chk_addr[19:16] = 4'h6: e = chk_addr[4 +: AW], ch = chk_addr[3:0]. Returns 0 if ch >= NCH or e >= sample_cnt.
  - chk_addr[19:16] = 4'h7, by chk_addr[3:0]:
    - 0: trace_state.
    - 1: sample_cnt.
    - 2: trigger position (trig_ptr - oldest) mod DEPTH. Valid in POST and DONE, 0 otherwise.
    - 3: trig_value.
    - 4: trig_mask.
    - 5: {halt_en, trig_ch, post_count} packed from bit 0 upward as post_count, trig_ch at [19:16], halt_en at bit 31.
    - Other indices return 0.
  - Any other region returns 0.

## Timing
- Reset (asynchronous): chk_data = 0, trace_state = IDLE, halt = 0, all counters and pointers 0, config registers 0. Memory contents are unspecified, but are unreadable because sample_cnt = 0.
- Read latency is 1 cycle: chk_data at edge N+1 reflects chk_addr and state sampled at edge N.
- A read in the same cycle as a capture returns pre-capture contents and counters.
- Trigger to DONE:
  - post_count = 0: trace_state = DONE and halt (if halt_en) on the edge that captures the trigger sample.
  - Otherwise DONE follows the edge that captures the post_count-th sample after the trigger.
- Reset asserted mid-capture aborts immediately, with no partial state retained.
- Wrap-around: once full, each capture overwrites the oldest entry. post_count saturation at DEPTH-1 guarantees the trigger sample survives.

## Test plan
- Reset: assert rstn = 0 mid-POST -> chk_data = 0, halt = 0, trace_state = 0, status register 1 reads 0 after release.
- Pre/post trigger (DEPTH = 8, NCH = 4): arm, trig_ch = 1, trig_value = 0x40, trig_mask = 0xFFFFFFFF, post_count = 2. Feed samples i = 0..9 with ch1 = 0x10*i -> DONE after i = 6; sample_cnt = 7; trigger position = 4; read 0x60041 -> 0x40 one cycle later.
- Wrap (DEPTH = 8): post_count = 3, trigger value 0xC0, feed i = 0..15 -> sample_cnt = 8; trigger position = 4; entry 0 ch1 = 0x80; entry 7 ch1 = 0xF0.
- Halt: halt_en = 1, post_count = 0, trig_mask = 0 -> halt = 1 on the first valid sample's edge, entry 0 holds it; write clear -> halt = 0 on the next edge.
- Simultaneous events: arm with probe_valid = 1 in the same cycle -> sample_cnt = 0; arm and clear together -> state IDLE; probe_valid in DONE -> no change.
- Out of range: chk_addr = 0x1 -> 0; channel 5 with NCH = 4 -> 0; entry 7 with sample_cnt = 3 -> 0; trig_ch = 9 -> never triggers.

Source files
------------

// File: rtl/debug_trace_unit.sv
// Trace-capture unit: samples NCH probe channels into a circular buffer, stops a
// programmable number of samples after a masked-compare trigger, and reads back over chk_addr/chk_data.
module debug_trace_unit #(
  parameter int unsigned DW    = 32,
  parameter int unsigned NCH   = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NCH*DW-1:0] probe_bus,
  input  logic              probe_valid,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic [31:0]       chk_addr,
  output logic [31:0]       chk_data,
  output logic [1:0]        trace_state,
  output logic              halt
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PC_MAX   = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                halt_q, halt_d;
  logic                halt_en_q, halt_en_d;
  logic [3:0]          trig_ch_q;
  logic [DW-1:0]       trig_value_q;
  logic [DW-1:0]       trig_mask_q;
  logic [AW-1:0]       post_count_q;
  logic [AW-1:0]       wr_ptr_q;
  logic [AW:0]         sample_cnt_q;
  logic [AW-1:0]       trig_ptr_q;
  logic [AW-1:0]       remain_q;
  logic [31:0]         chk_data_q;
  logic [NCH*DW-1:0]   mem [DEPTH];

  logic                ctrl_we, cmd_clear, cmd_arm, cmd_any;
  logic                capture, ch_ok, fire;
  logic [DW-1:0]       trig_word;
  logic [AW-1:0]       oldest, rd_entry, rd_idx;
  logic [3:0]          rd_ch;
  logic [NCH*DW-1:0]   rd_word;
  logic [DW-1:0]       rd_ch_word;
  logic [31:0]         rd_data_d;
  logic [31:0]         cfg_pack;
  logic                unused_bits;

  assign unused_bits = ^{chk_addr, cfg_wdata};

  // Command decode; clear overrides arm, and any command suppresses capture that cycle
  assign ctrl_we   = cfg_we && (cfg_addr == 3'd0);
  assign cmd_clear = ctrl_we && cfg_wdata[2];
  assign cmd_arm   = ctrl_we && cfg_wdata[0] && !cfg_wdata[2];
  assign cmd_any   = ctrl_we && (cfg_wdata[0] || cfg_wdata[2]);
  assign capture   = probe_valid && !cmd_any && ((state_q == ST_ARMED) || (state_q == ST_POST));

  always_comb begin
    trig_word = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (32'(trig_ch_q) == k) trig_word = probe_bus[k*DW +: DW];
    end
  end

  assign ch_ok = 32'(trig_ch_q) < NCH;
  assign fire  = capture && (state_q == ST_ARMED) && ch_ok &&
                 (((trig_word ^ trig_value_q) & trig_mask_q) == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    halt_en_d = halt_en_q;
    halt_d    = 1'b0;
    if (ctrl_we) halt_en_d = cfg_wdata[1];
    if (cmd_clear) begin
      state_d = ST_IDLE;
    end else if (cmd_arm) begin
      state_d = ST_ARMED;
    end else if (fire) begin
      state_d = (post_count_q == '0) ? ST_DONE : ST_POST;
    end else if (capture && (state_q == ST_POST) && (remain_q == AW'(1))) begin
      state_d = ST_DONE;
    end
    halt_d = (state_d == ST_DONE) && halt_en_d;
  end

  // Config registers, pointers and counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halt_en_q    <= 1'b0;
      trig_ch_q    <= '0;
      trig_value_q <= '0;
      trig_mask_q  <= '0;
      post_count_q <= '0;
      wr_ptr_q     <= '0;
      sample_cnt_q <= '0;
      trig_ptr_q   <= '0;
      remain_q     <= '0;
    end else begin
      halt_en_q <= halt_en_d;
      if (cfg_we) begin
        case (cfg_addr)
          3'd1: trig_ch_q    <= cfg_wdata[3:0];
          3'd2: trig_value_q <= cfg_wdata[DW-1:0];
          3'd3: trig_mask_q  <= cfg_wdata[DW-1:0];
          3'd4: post_count_q <= (cfg_wdata > 32'(DEPTH - 1)) ? PC_MAX : cfg_wdata[AW-1:0];
          default: ;
        endcase
      end
      if (cmd_any) begin
        wr_ptr_q     <= '0;
        sample_cnt_q <= '0;
        trig_ptr_q   <= '0;
      end else if (capture) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (sample_cnt_q != CNT_FULL) sample_cnt_q <= sample_cnt_q + (AW+1)'(1);
        if (fire) begin
          trig_ptr_q <= wr_ptr_q;
          remain_q   <= post_count_q;
        end else if (state_q == ST_POST) begin
          remain_q <= remain_q - AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr_q] <= probe_bus;
  end

  // Read path: logical entries are indexed from the oldest surviving sample
  assign oldest   = wr_ptr_q - sample_cnt_q[AW-1:0];
  assign rd_entry = chk_addr[4 +: AW];
  assign rd_ch    = chk_addr[3:0];
  assign rd_idx   = oldest + rd_entry;
  assign rd_word  = mem[rd_idx];

  always_comb begin
    rd_ch_word = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (32'(rd_ch) == k) rd_ch_word = rd_word[k*DW +: DW];
    end
  end

  always_comb begin
    cfg_pack          = '0;
    cfg_pack[AW-1:0]  = post_count_q;
    cfg_pack[19:16]   = trig_ch_q;
    cfg_pack[31]      = halt_en_q;
  end

  always_comb begin
    rd_data_d = '0;
    case (chk_addr[19:16])
      4'h6: begin
        if ((32'(rd_ch) < NCH) && ({1'b0, rd_entry} < sample_cnt_q)) rd_data_d = 32'(rd_ch_word);
      end
      4'h7: begin
        case (chk_addr[3:0])
          4'd0: rd_data_d = 32'(state_q);
          4'd1: rd_data_d = 32'(sample_cnt_q);
          4'd2: rd_data_d = ((state_q == ST_POST) || (state_q == ST_DONE)) ?
                            32'(AW'(trig_ptr_q - oldest)) : 32'd0;
          4'd3: rd_data_d = 32'(trig_value_q);
          4'd4: rd_data_d = 32'(trig_mask_q);
          4'd5: rd_data_d = cfg_pack;
          default: rd_data_d = '0;
        endcase
      end
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) chk_data_q <= '0;
    else       chk_data_q <= rd_data_d;
  end

  assign chk_data    = chk_data_q;
  assign trace_state = state_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_debug_trace_unit.sv
// Directed bench for debug_trace_unit (DEPTH=8, NCH=4): read expectations are queued
// when the address is driven and compared when chk_data is produced a cycle later.
module tb_debug_trace_unit;

  localparam int unsigned DW    = 32;
  localparam int unsigned NCH   = 4;
  localparam int unsigned DEPTH = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NCH*DW-1:0] probe_bus;
  logic              probe_valid;
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [31:0]       cfg_wdata;
  logic [31:0]       chk_addr;
  logic [31:0]       chk_data;
  logic [1:0]        trace_state;
  logic              halt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  debug_trace_unit #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .probe_bus(probe_bus), .probe_valid(probe_valid),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .chk_addr(chk_addr), .chk_data(chk_data), .trace_state(trace_state), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Channel k of sample i: ch0=0xA00+i, ch1=0x10*i, ch2=0x200+i, ch3=0x300+i
  task automatic set_probe(input int i);
    probe_bus = {32'(32'h300 + i), 32'(32'h200 + i), 32'(32'h10 * i), 32'(32'hA00 + i)};
  endtask

  task automatic sample(input int i);
    set_probe(i);
    probe_valid = 1'b1;
    tick();
    probe_valid = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    chk_addr = addr;
    exp_q.push_back(exp);
    tick();
    if (exp_q.size() == 0) check({tag, "_noexp"}, chk_data, 32'hFFFF_FFFF);
    else                   check(tag, chk_data, exp_q.pop_front());
  endtask

  initial begin
    rstn = 1'b0; probe_bus = '0; probe_valid = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; chk_addr = '0;
    repeat (2) tick();
    check("rst_chk_data", chk_data, 32'd0);
    check("rst_state", 32'(trace_state), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    rstn = 1'b1;
    tick();
    rd(32'h70000, 32'd0, "rst_status0");
    rd(32'h70001, 32'd0, "rst_status1");

    // Pre/post trigger window
    cfg(3'd1, 32'd1);
    cfg(3'd2, 32'h40);
    cfg(3'd3, 32'hFFFF_FFFF);
    cfg(3'd4, 32'd2);
    cfg(3'd0, 32'd1);
    check("pp_armed", 32'(trace_state), 32'd1);
    for (int i = 0; i < 10; i++) begin
      sample(i);
      check($sformatf("pp_state_%0d", i), 32'(trace_state), (i < 4) ? 32'd1 : (i < 6) ? 32'd2 : 32'd3);
    end
    rd(32'h70001, 32'd7, "pp_sample_cnt");
    rd(32'h70002, 32'd4, "pp_trig_pos");
    rd(32'h60041, 32'h40, "pp_e4_ch1");
    rd(32'h60000, 32'hA00, "pp_e0_ch0");
    rd(32'h60063, 32'h306, "pp_e6_ch3");
    rd(32'h70005, 32'h0001_0002, "pp_cfg_pack");
    rd(32'h70003, 32'h40, "pp_trig_value");
    rd(32'h70004, 32'hFFFF_FFFF, "pp_trig_mask");
    rd(32'h00001, 32'd0, "oor_region");
    rd(32'h60075, 32'd0, "oor_channel");
    rd(32'h60071, 32'd0, "oor_entry_eq_cnt");
    rd(32'h70006, 32'd0, "oor_status_idx");

    // Wrap-around
    cfg(3'd2, 32'hC0);
    cfg(3'd4, 32'd3);
    cfg(3'd0, 32'd1);
    for (int i = 0; i < 16; i++) sample(i);
    check("wr_state", 32'(trace_state), 32'd3);
    check("wr_halt", 32'(halt), 32'd0);
    rd(32'h70001, 32'd8, "wr_sample_cnt");
    rd(32'h70002, 32'd4, "wr_trig_pos");
    rd(32'h60001, 32'h80, "wr_e0_ch1");
    rd(32'h60071, 32'hF0, "wr_e7_ch1");
    rd(32'h60070, 32'hA0F, "wr_e7_ch0");
    sample(20);
    rd(32'h70001, 32'd8, "done_no_capture_cnt");
    rd(32'h60071, 32'hF0, "done_no_capture_data");

    // Halt on immediate trigger
    cfg(3'd3, 32'd0);
    cfg(3'd4, 32'd0);
    cfg(3'd0, 32'd3);
    check("h_armed", 32'(trace_state), 32'd1);
    check("h_halt_low", 32'(halt), 32'd0);
    sample(5);
    check("h_halt_high", 32'(halt), 32'd1);
    check("h_state_done", 32'(trace_state), 32'd3);
    rd(32'h60001, 32'h50, "h_e0_ch1");
    rd(32'h70001, 32'd1, "h_sample_cnt");
    rd(32'h70002, 32'd0, "h_trig_pos");
    cfg(3'd0, 32'd6);
    check("h_clear_halt", 32'(halt), 32'd0);
    check("h_clear_state", 32'(trace_state), 32'd0);

    // Simultaneous command and sample
    cfg(3'd3, 32'hFFFF_FFFF);
    cfg(3'd2, 32'hDEAD);
    cfg(3'd4, 32'd2);
    set_probe(1);
    probe_valid = 1'b1;
    cfg(3'd0, 32'd1);
    probe_valid = 1'b0;
    rd(32'h70001, 32'd0, "sim_arm_no_capture");
    check("sim_arm_state", 32'(trace_state), 32'd1);
    cfg(3'd0, 32'd5);
    check("sim_clear_wins", 32'(trace_state), 32'd0);

    // Partial fill, capture-during-read, unreachable trigger channel
    cfg(3'd0, 32'd1);
    for (int i = 0; i < 3; i++) sample(i);
    rd(32'h70001, 32'd3, "pf_sample_cnt");
    rd(32'h60071, 32'd0, "pf_e7_empty");
    rd(32'h60021, 32'h20, "pf_e2_ch1");
    rd(32'h70002, 32'd0, "pf_trig_pos_armed");
    chk_addr = 32'h70001;
    exp_q.push_back(32'd3);
    set_probe(3);
    probe_valid = 1'b1;
    tick();
    probe_valid = 1'b0;
    check("rdcap_pre_capture", chk_data, exp_q.pop_front());
    rd(32'h70001, 32'd4, "rdcap_post_capture");
    cfg(3'd1, 32'd9);
    cfg(3'd3, 32'd0);
    for (int i = 0; i < 10; i++) sample(i);
    check("tc9_no_trigger", 32'(trace_state), 32'd1);
    rd(32'h70001, 32'd8, "cnt_saturate");
    cfg(3'd4, 32'd100);
    rd(32'h70005, 32'h0009_0007, "post_count_sat");

    // Reset in the middle of POST
    cfg(3'd1, 32'd1);
    cfg(3'd3, 32'hFFFF_FFFF);
    cfg(3'd2, 32'h20);
    cfg(3'd4, 32'd5);
    cfg(3'd0, 32'd3);
    for (int i = 0; i < 4; i++) sample(i);
    check("mr_in_post", 32'(trace_state), 32'd2);
    rd(32'h70001, 32'd4, "mr_cnt_before");
    rstn = 1'b0;
    #2;
    check("mr_chk_data", chk_data, 32'd0);
    check("mr_state", 32'(trace_state), 32'd0);
    check("mr_halt", 32'(halt), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    rd(32'h70001, 32'd0, "mr_status1");
    rd(32'h70005, 32'd0, "mr_cfg_pack");
    rd(32'h70003, 32'd0, "mr_trig_value");
    rd(32'h70004, 32'd0, "mr_trig_mask");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
